// File: rtl/writeback_stage.sv
// ============================================================================
// writeback_stage : final pipeline stage - writeback mux, 32x32 register file
//                   with same-cycle read bypass, forwarding register, and
//                   optional retired-instruction counter (macro WB_INSTRET_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            WB_CLOCK,
    input  logic            WB_RESET,
    input  logic            MEM_REG_VALID,
    input  logic            MEM_REG_WRITE,
    input  logic [1:0]      MEM_RF_WR_SEL,
    input  logic [4:0]      MS_WB_RD,
    input  logic [XLEN-1:0] MEM_REG_PC_4,
    input  logic [XLEN-1:0] MEM_REG_DOUT2,
    input  logic [XLEN-1:0] MEM_REG_ALU_RESULT,
    input  logic [XLEN-1:0] WB_CSR_RD,
    input  logic [4:0]      DEC_RS1_ADDR,
    input  logic [4:0]      DEC_RS2_ADDR,
    output logic [XLEN-1:0] WB_RS1_DATA,
    output logic [XLEN-1:0] WB_RS2_DATA,
    output logic            WB_FWD_EN,
    output logic [4:0]      WB_FWD_RD,
    output logic [XLEN-1:0] WB_FWD_DATA,
    output logic [63:0]     WB_INSTRET
);

    localparam logic [1:0] c_SEL_PC4  = 2'd0;
    localparam logic [1:0] c_SEL_CSR  = 2'd1;
    localparam logic [1:0] c_SEL_LOAD = 2'd2;

    logic [XLEN-1:0] r_regs [0:NREGS-1];
    logic [XLEN-1:0] w_wb_data;
    logic            w_we;

    always_comb begin
        case (MEM_RF_WR_SEL)
            c_SEL_PC4:  w_wb_data = MEM_REG_PC_4;
            c_SEL_CSR:  w_wb_data = WB_CSR_RD;
            c_SEL_LOAD: w_wb_data = MEM_REG_DOUT2;
            default:    w_wb_data = MEM_REG_ALU_RESULT;
        endcase
    end

    assign w_we = MEM_REG_VALID & MEM_REG_WRITE & (MS_WB_RD != 5'd0);

    // Array writes on the falling edge so the value is in the array for the next cycle.
    always_ff @(negedge WB_CLOCK or negedge WB_RESET) begin
        if (!WB_RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[MS_WB_RD] <= w_wb_data;
        end
    end

    always_comb begin
        if (DEC_RS1_ADDR == 5'd0) begin
            WB_RS1_DATA = '0;
        end else if (w_we && (DEC_RS1_ADDR == MS_WB_RD)) begin
            WB_RS1_DATA = w_wb_data;
        end else begin
            WB_RS1_DATA = r_regs[DEC_RS1_ADDR];
        end
    end

    always_comb begin
        if (DEC_RS2_ADDR == 5'd0) begin
            WB_RS2_DATA = '0;
        end else if (w_we && (DEC_RS2_ADDR == MS_WB_RD)) begin
            WB_RS2_DATA = w_wb_data;
        end else begin
            WB_RS2_DATA = r_regs[DEC_RS2_ADDR];
        end
    end

    // Forwarding rd/data hold their last written values across non-writing cycles.
    always_ff @(posedge WB_CLOCK or negedge WB_RESET) begin
        if (!WB_RESET) begin
            WB_FWD_EN   <= 1'b0;
            WB_FWD_RD   <= 5'd0;
            WB_FWD_DATA <= '0;
        end else begin
            WB_FWD_EN <= w_we;
            if (w_we) begin
                WB_FWD_RD   <= MS_WB_RD;
                WB_FWD_DATA <= w_wb_data;
            end
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge WB_CLOCK or negedge WB_RESET) begin
        if (!WB_RESET) begin
            r_instret <= 64'd0;
        end else if (MEM_REG_VALID) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign WB_INSTRET = r_instret;
`else
    assign WB_INSTRET = 64'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
// tb_writeback_stage : randomized + directed bench for writeback_stage with a
//                      behavioural register-file model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        valid, wr;
    logic [1:0]  sel;
    logic [4:0]  rd, a1, a2;
    logic [31:0] pc4, dout, alu, csr;
    logic [31:0] rs1, rs2, fwd_data;
    logic        fwd_en;
    logic [4:0]  fwd_rd;
    logic [63:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_rf [0:31];
    logic        m_fwd_en;
    logic [4:0]  m_fwd_rd;
    logic [31:0] m_fwd_data;
    logic [63:0] m_instret;

    writeback_stage dut (
        .WB_CLOCK           (clk),
        .WB_RESET           (rst_n),
        .MEM_REG_VALID      (valid),
        .MEM_REG_WRITE      (wr),
        .MEM_RF_WR_SEL      (sel),
        .MS_WB_RD           (rd),
        .MEM_REG_PC_4       (pc4),
        .MEM_REG_DOUT2      (dout),
        .MEM_REG_ALU_RESULT (alu),
        .WB_CSR_RD          (csr),
        .DEC_RS1_ADDR       (a1),
        .DEC_RS2_ADDR       (a2),
        .WB_RS1_DATA        (rs1),
        .WB_RS2_DATA        (rs2),
        .WB_FWD_EN          (fwd_en),
        .WB_FWD_RD          (fwd_rd),
        .WB_FWD_DATA        (fwd_data),
        .WB_INSTRET         (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_fwd_en   = 1'b0;
        m_fwd_rd   = 5'd0;
        m_fwd_data = 32'd0;
        m_instret  = 64'd0;
    endtask

    function automatic logic [31:0] wb_value();
        case (sel)
            2'd0:    return pc4;
            2'd1:    return csr;
            2'd2:    return dout;
            default: return alu;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] addr);
        logic we;
        we = valid && wr && (rd != 5'd0);
        if (addr == 5'd0) return 32'd0;
        if (we && addr == rd) return wb_value();
        return m_rf[addr];
    endfunction

    // One full cycle; entered and left at posedge+1.
    task automatic cycle(input logic v, input logic w, input logic [1:0] s, input logic [4:0] d,
                         input logic [31:0] p, input logic [31:0] c, input logic [31:0] ld,
                         input logic [31:0] al, input logic [4:0] r1, input logic [4:0] r2);
        logic we;
        valid = v; wr = w; sel = s; rd = d;
        pc4 = p; csr = c; dout = ld; alu = al; a1 = r1; a2 = r2;
        we = v && w && (d != 5'd0);
        #2;
        check("rs1_bypass", {32'd0, rs1}, {32'd0, exp_read(r1)});
        check("rs2_bypass", {32'd0, rs2}, {32'd0, exp_read(r2)});
        check("fwd_en", {63'd0, fwd_en}, {63'd0, m_fwd_en});
        check("fwd_rd", {59'd0, fwd_rd}, {59'd0, m_fwd_rd});
        check("fwd_data", {32'd0, fwd_data}, {32'd0, m_fwd_data});
`ifdef WB_INSTRET_EN
        check("instret", instret, m_instret);
`else
        check("instret", instret, 64'd0);
`endif
        @(negedge clk);
        if (we) m_rf[d] = wb_value();
        #1;
        check("rs1_after_wr", {32'd0, rs1}, {32'd0, exp_read(r1)});
        check("rs2_after_wr", {32'd0, rs2}, {32'd0, exp_read(r2)});
        @(posedge clk);
        m_fwd_en = we;
        if (we) begin
            m_fwd_rd   = d;
            m_fwd_data = wb_value();
        end
        if (v) m_instret = m_instret + 64'd1;
        #1;
    endtask

    initial begin
        logic [4:0] r;
        rst_n = 1'b0;
        valid = 0; wr = 0; sel = 0; rd = 0; pc4 = 0; dout = 0; alu = 0; csr = 0; a1 = 0; a2 = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state reads
        cycle(0, 0, 2'd0, 5'd0, 0, 0, 0, 0, 5'd5, 5'd31);
        // ALU writeback with bypass, then array read and forwarding
        cycle(1, 1, 2'd3, 5'd7, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 5'd7, 5'd7);
        cycle(0, 0, 2'd0, 5'd0, 0, 0, 0, 0, 5'd7, 5'd1);
        // Mux sources to x3
        cycle(1, 1, 2'd0, 5'd3, 32'h104, 32'h1800, 32'hFFFFFF80, 32'h1, 5'd3, 5'd0);
        cycle(1, 1, 2'd1, 5'd3, 32'h104, 32'h1800, 32'hFFFFFF80, 32'h1, 5'd3, 5'd3);
        cycle(1, 1, 2'd2, 5'd3, 32'h104, 32'h1800, 32'hFFFFFF80, 32'h1, 5'd3, 5'd7);
        cycle(0, 0, 2'd0, 5'd0, 0, 0, 0, 0, 5'd3, 5'd3);
        // x0 write attempt and bubble with write set
        cycle(1, 1, 2'd3, 5'd0, 0, 0, 0, 32'h55, 5'd0, 5'd3);
        cycle(0, 1, 2'd3, 5'd9, 0, 0, 0, 32'hABCD, 5'd9, 5'd9);
        cycle(0, 0, 2'd0, 5'd0, 0, 0, 0, 0, 5'd9, 5'd0);

        // Randomized traffic with frequent read-after-write collisions
        for (int i = 0; i < 300; i++) begin
            r = 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  2'($urandom), r, $urandom, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? r : 5'($urandom),
                  ($urandom_range(0, 2) == 0) ? r : 5'($urandom));
        end

        // Reset mid-cycle while an x4 write is in flight
        cycle(1, 1, 2'd3, 5'd4, 0, 0, 0, 32'h1234, 5'd4, 5'd0);
        valid = 1; wr = 1; sel = 2'd3; rd = 5'd4; alu = 32'h9999;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_fwd_en", {63'd0, fwd_en}, 64'd0);
        check("rst_fwd_rd", {59'd0, fwd_rd}, 64'd0);
        check("rst_fwd_data", {32'd0, fwd_data}, 64'd0);
        check("rst_instret", instret, 64'd0);
        @(posedge clk); #1;
        valid = 0; wr = 0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(0, 0, 2'd0, 5'd0, 0, 0, 0, 0, 5'd4, 5'd7);
        check("rst_x4_zero", {32'd0, rs1}, 64'd0);

        // 10 retired instructions with 3 bubbles interleaved
        for (int i = 0; i < 13; i++) begin
            cycle((i % 4) != 3, 1'b1, 2'd3, 5'($urandom_range(1, 31)), 0, 0, 0, $urandom,
                  5'($urandom), 5'($urandom));
        end
`ifdef WB_INSTRET_EN
        check("instret_10", instret, 64'd10);
`else
        check("instret_off", instret, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Sits directly downstream of the memory stage and consumes its registered outputs.
- Selects the writeback value per rf_wr_sel, writes it into the 32x32 register file, and serves the decode stage's two combinational read ports with same-cycle write bypass.
- Drives forwarding info to execute and, optionally, a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, data width of registers and datapath
- NREGS, 32, number of architectural registers (x0 hardwired zero)

Ports:
- WB_CLOCK  in  1  stage clock
- WB_RESET  in  1  asynchronous reset, active-low (0 = reset asserted)
- MEM_REG_VALID  in  1  instruction in WB is real (0 = bubble)
- MEM_REG_WRITE  in  1  instruction writes rd
- MEM_RF_WR_SEL  in  2  writeback source select
- MS_WB_RD  in  5  destination register index
- MEM_REG_PC_4  in  XLEN  PC+4 of instruction
- MEM_REG_DOUT2  in  XLEN  load data, already sized/extended by memory
- MEM_REG_ALU_RESULT  in  XLEN  ALU result
- WB_CSR_RD  in  XLEN  CSR read data
- DEC_RS1_ADDR  in  5  decode read port 1 address
- DEC_RS2_ADDR  in  5  decode read port 2 address
- WB_RS1_DATA  out  XLEN  read port 1 data
- WB_RS2_DATA  out  XLEN  read port 2 data
- WB_FWD_EN  out  1  registered: a write retired last cycle
- WB_FWD_RD  out  5  registered rd of that write
- WB_FWD_DATA  out  XLEN  registered data of that write
- WB_INSTRET  out  64  retired instruction count (feature-dependent)

Behaviour:
- Writeback mux (combinational): 0 = MEM_REG_PC_4; 1 = WB_CSR_RD; 2 = MEM_REG_DOUT2; 3 = MEM_REG_ALU_RESULT.
- Write enable: we = MEM_REG_VALID & MEM_REG_WRITE & (MS_WB_RD != 0).
- Register write occurs on negedge WB_CLOCK when we=1 and WB_RESET=1.
- x0 is never written; reads of x0 always return 0.
- Read ports are combinational.
  - If DEC_RSn_ADDR == MS_WB_RD, we=1, and the address is nonzero, output the mux value (bypass) for the whole cycle.
  - Otherwise output the array contents.
  - Both ports bypass independently, including both ports at the same address.
- Forwarding register updates on posedge WB_CLOCK:
  - WB_FWD_EN <= we; WB_FWD_RD <= MS_WB_RD; WB_FWD_DATA <= mux value.
  - When we=0: FWD_EN=0, and FWD_RD/FWD_DATA hold their previous values.
- Latency: a value presented in cycle N is readable via bypass in cycle N, from the array from cycle N+1, and on the forwarding outputs from posedge N+1.
- Reset (asynchronous, any time WB_RESET=0):
  - All registers x1..x31 clear to 0.
  - WB_FWD_EN=0, WB_FWD_RD=0, WB_FWD_DATA=0, WB_INSTRET=0.
  - Writes are suppressed while reset is asserted.
  - An instruction present when reset asserts mid-cycle is lost (not retried).
- Reset release: the first negedge after WB_RESET rises may write.
- Bubble (MEM_REG_VALID=0): no write, no forward, no instret increment, regardless of MEM_REG_WRITE.
- rd = 0 with MEM_REG_WRITE=1: counts as retired, no write, WB_FWD_EN=0.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - 64-bit counter increments by 1 on posedge WB_CLOCK for each MEM_REG_VALID=1 cycle.
  - Wraps from 2^64-1 to 0 without flag.
  - Reset clears it to 0.
  - WB_INSTRET shows the registered count.
- Undefined: no counter logic; WB_INSTRET tied to 0.

Test Plan:
- Reset then read: WB_RESET=0 then 1; DEC_RS1_ADDR=5, DEC_RS2_ADDR=31 -> both read 0x00000000; FWD_EN=0; INSTRET=0.
- ALU writeback: VALID=1, WRITE=1, SEL=3, RD=7, ALU=0xDEADBEEF; DEC_RS1_ADDR=7 same cycle -> RS1=0xDEADBEEF (bypass); next cycle from array 0xDEADBEEF; FWD_EN=1, FWD_RD=7, FWD_DATA=0xDEADBEEF.
- Mux sources: RD=3 with SEL=0 (PC_4=0x104), then SEL=1 (CSR=0x1800), then SEL=2 (DOUT2=0xFFFFFF80) in consecutive cycles -> x3 reads 0x104, 0x1800, 0xFFFFFF80 in successive cycles.
- x0 and bubbles: RD=0, ALU=0x55 -> x0 reads 0, FWD_EN=0, INSTRET+1; VALID=0, WRITE=1, RD=9 -> x9 unchanged, FWD_EN=0, INSTRET unchanged.
- Reset mid-operation: write x4=0x1234; assert WB_RESET low between posedge and negedge while RD=4, ALU=0x9999 -> x4 reads 0, INSTRET=0, FWD outputs 0.
- WB_INSTRET_EN: 10 valid cycles with 3 bubbles interleaved -> WB_INSTRET=10; built without macro -> WB_INSTRET stays 0.
